// File: rtl/audio_sample_reader_if.sv
// Read-port bundle between the sample reader and the dual-port audio buffer.
// The reader is the master: it drives enables/address and receives halfword read data.
interface audio_sample_reader_if;
  logic        buf_ceb;
  logic        buf_oce;
  logic [1:0]  buf_adb;
  logic [15:0] buf_dout;

  modport master (output buf_ceb, output buf_oce, output buf_adb, input buf_dout);
  modport slave  (input buf_ceb, input buf_oce, input buf_adb, output buf_dout);
endinterface

// File: rtl/audio_sample_reader.sv
// Double-buffered stereo sample reader: on each enabled sample tick it pulls one
// 32-bit stereo word out of a two-word buffer as two halfword reads and presents it as PCM.
module audio_sample_reader #(
  parameter bit HOLD_ON_UNDERRUN = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable_i,
  input  logic                          sample_tick_i,
  input  logic                          wr_strobe_i,
  input  logic                          wr_word_i,
  audio_sample_reader_if.master         buf_if,
  output logic [15:0]                   pcm_left_o,
  output logic [15:0]                   pcm_right_o,
  output logic                          pcm_valid_o,
  output logic                          refill_req_o,
  output logic                          refill_word_o,
  output logic                          underrun_o,
  output logic                          tick_overrun_o
);

  typedef enum logic [1:0] {IDLE, RD_L, RD_R} state_t;

  state_t      state_q, state_d;
  logic        rd_word_q, rd_word_d;
  logic [1:0]  full_q, full_d;
  logic [1:0]  adb_q, adb_d;
  logic [15:0] left_q, left_d;
  logic [15:0] pcm_left_q, pcm_left_d;
  logic [15:0] pcm_right_q, pcm_right_d;
  logic        pcm_valid_q, pcm_valid_d;
  logic        refill_req_q, refill_req_d;
  logic        refill_word_q, refill_word_d;
  logic        underrun_q, underrun_d;
  logic        tick_overrun_q, tick_overrun_d;
  logic        ceb;
  logic        tick_act;

  assign tick_act = sample_tick_i & enable_i;

  always_comb begin
    state_d        = state_q;
    rd_word_d      = rd_word_q;
    full_d         = full_q;
    adb_d          = adb_q;
    left_d         = left_q;
    pcm_left_d     = pcm_left_q;
    pcm_right_d    = pcm_right_q;
    pcm_valid_d    = 1'b0;
    refill_req_d   = 1'b0;
    refill_word_d  = refill_word_q;
    underrun_d     = 1'b0;
    tick_overrun_d = 1'b0;
    ceb            = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tick_act) begin
          if (full_q[rd_word_q]) begin
            state_d = RD_L;
            ceb     = 1'b1;
            adb_d   = {rd_word_q, 1'b0};
          end else begin
            underrun_d  = 1'b1;
            pcm_valid_d = 1'b1;
            if (!HOLD_ON_UNDERRUN) begin
              pcm_left_d  = '0;
              pcm_right_d = '0;
            end
          end
        end
      end
      RD_L: begin
        // Left halfword requested in the previous cycle arrives now.
        ceb            = 1'b1;
        adb_d          = {rd_word_q, 1'b1};
        left_d         = buf_if.buf_dout;
        tick_overrun_d = tick_act;
        state_d        = RD_R;
      end
      RD_R: begin
        pcm_left_d        = left_q;
        pcm_right_d       = buf_if.buf_dout;
        pcm_valid_d       = 1'b1;
        refill_req_d      = 1'b1;
        refill_word_d     = rd_word_q;
        full_d[rd_word_q] = 1'b0;
        rd_word_d         = ~rd_word_q;
        tick_overrun_d    = tick_act;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Applied after the consume-clear so a same-cycle write keeps the word full.
    if (wr_strobe_i) full_d[wr_word_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rd_word_q      <= 1'b0;
      full_q         <= 2'b00;
      adb_q          <= 2'b00;
      left_q         <= '0;
      pcm_left_q     <= '0;
      pcm_right_q    <= '0;
      pcm_valid_q    <= 1'b0;
      refill_req_q   <= 1'b0;
      refill_word_q  <= 1'b0;
      underrun_q     <= 1'b0;
      tick_overrun_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rd_word_q      <= rd_word_d;
      full_q         <= full_d;
      adb_q          <= adb_d;
      left_q         <= left_d;
      pcm_left_q     <= pcm_left_d;
      pcm_right_q    <= pcm_right_d;
      pcm_valid_q    <= pcm_valid_d;
      refill_req_q   <= refill_req_d;
      refill_word_q  <= refill_word_d;
      underrun_q     <= underrun_d;
      tick_overrun_q <= tick_overrun_d;
    end
  end

  // Address is presented in the request cycle and held between reads.
  assign buf_if.buf_ceb = ceb;
  assign buf_if.buf_oce = 1'b1;
  assign buf_if.buf_adb = adb_d;

  assign pcm_left_o     = pcm_left_q;
  assign pcm_right_o    = pcm_right_q;
  assign pcm_valid_o    = pcm_valid_q;
  assign refill_req_o   = refill_req_q;
  assign refill_word_o  = refill_word_q;
  assign underrun_o     = underrun_q;
  assign tick_overrun_o = tick_overrun_q;

endmodule

// File: tb/tb_audio_sample_reader.sv
// Directed bench for audio_sample_reader: one instance per underrun policy,
// shared stimulus, behavioural two-word buffer with a registered read port.
module tb_audio_sample_reader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic sample_tick = 1'b0;
  logic wr_strobe = 1'b0;
  logic wr_word = 1'b0;

  logic [15:0] left0, right0, left1, right1;
  logic valid0, rreq0, rword0, und0, ovr0;
  logic valid1, rreq1, rword1, und1, ovr1;

  int total = 0;
  int bad = 0;

  logic [31:0] mem [0:1];

  audio_sample_reader_if bif0();
  audio_sample_reader_if bif1();

  audio_sample_reader #(.HOLD_ON_UNDERRUN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .sample_tick_i(sample_tick),
    .wr_strobe_i(wr_strobe), .wr_word_i(wr_word), .buf_if(bif0),
    .pcm_left_o(left0), .pcm_right_o(right0), .pcm_valid_o(valid0),
    .refill_req_o(rreq0), .refill_word_o(rword0), .underrun_o(und0),
    .tick_overrun_o(ovr0));

  audio_sample_reader #(.HOLD_ON_UNDERRUN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .sample_tick_i(sample_tick),
    .wr_strobe_i(wr_strobe), .wr_word_i(wr_word), .buf_if(bif1),
    .pcm_left_o(left1), .pcm_right_o(right1), .pcm_valid_o(valid1),
    .refill_req_o(rreq1), .refill_word_o(rword1), .underrun_o(und1),
    .tick_overrun_o(ovr1));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bif0.buf_ceb)
      bif0.buf_dout <= bif0.buf_adb[0] ? mem[bif0.buf_adb[1]][31:16] : mem[bif0.buf_adb[1]][15:0];
    if (bif1.buf_ceb)
      bif1.buf_dout <= bif1.buf_adb[0] ? mem[bif1.buf_adb[1]][31:16] : mem[bif1.buf_adb[1]][15:0];
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic w, input logic [31:0] data);
    cyc();
    mem[w] = data;
    wr_strobe = 1'b1;
    wr_word = w;
    cyc();
    wr_strobe = 1'b0;
  endtask

  // Issues one tick and records what dut0 shows in cycles T..T+3.
  task automatic run_read(output logic ceb_t, output logic [1:0] adb_t,
                          output logic ceb_t1, output logic [1:0] adb_t1,
                          output logic v_t2, output logic v_t3,
                          output logic [15:0] l_t3, output logic [15:0] r_t3,
                          output logic rq_t3, output logic rw_t3);
    cyc();
    sample_tick = 1'b1;
    #1;
    ceb_t = bif0.buf_ceb; adb_t = bif0.buf_adb;
    cyc();
    sample_tick = 1'b0;
    #1;
    ceb_t1 = bif0.buf_ceb; adb_t1 = bif0.buf_adb;
    cyc();
    v_t2 = valid0;
    cyc();
    v_t3 = valid0; l_t3 = left0; r_t3 = right0; rq_t3 = rreq0; rw_t3 = rword0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (bif0.buf_ceb !== 1'b0) begin bad++; $display("FAIL reset_ceb got=%b want=0", bif0.buf_ceb); end
    total++; if (bif0.buf_adb !== 2'd0) begin bad++; $display("FAIL reset_adb got=%0d want=0", bif0.buf_adb); end
    total++; if (bif0.buf_oce !== 1'b1) begin bad++; $display("FAIL reset_oce got=%b want=1", bif0.buf_oce); end
    total++; if ({left0, right0} !== 32'h0) begin bad++; $display("FAIL reset_pcm got=%h want=0", {left0, right0}); end
    total++; if ({valid0, rreq0, rword0, und0, ovr0} !== 5'b0) begin bad++; $display("FAIL reset_pulses got=%b want=00000", {valid0, rreq0, rword0, und0, ovr0}); end
    repeat (3) cyc();
    rst_n = 1'b1;
    enable = 1'b1;
  endtask

  task automatic test_first_underrun();
    cyc();
    sample_tick = 1'b1;
    #1;
    total++; if (bif0.buf_ceb !== 1'b0) begin bad++; $display("FAIL first_und_ceb got=%b want=0", bif0.buf_ceb); end
    cyc();
    sample_tick = 1'b0;
    total++; if (und0 !== 1'b1) begin bad++; $display("FAIL first_und_flag got=%b want=1", und0); end
    total++; if (valid0 !== 1'b1) begin bad++; $display("FAIL first_und_valid got=%b want=1", valid0); end
    total++; if ({left0, right0} !== 32'h0) begin bad++; $display("FAIL first_und_pcm got=%h want=0", {left0, right0}); end
    total++; if (und1 !== 1'b1) begin bad++; $display("FAIL first_und_hold_flag got=%b want=1", und1); end
    cyc();
    total++; if ({valid0, und0} !== 2'b00) begin bad++; $display("FAIL first_und_oneshot got=%b want=00", {valid0, und0}); end
  endtask

  task automatic test_basic();
    logic c0, c1, v2, v3, rq, rw;
    logic [1:0] a0, a1;
    logic [15:0] l, r;
    write_word(1'b0, 32'hBBBB_AAAA);
    run_read(c0, a0, c1, a1, v2, v3, l, r, rq, rw);
    total++; if ({c0, a0} !== 3'b1_00) begin bad++; $display("FAIL basic_T got ceb/adb=%b/%0d want 1/0", c0, a0); end
    total++; if ({c1, a1} !== 3'b1_01) begin bad++; $display("FAIL basic_T1 got ceb/adb=%b/%0d want 1/1", c1, a1); end
    total++; if (v2 !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b want=0", v2); end
    total++; if (v3 !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", v3); end
    total++; if (l !== 16'hAAAA) begin bad++; $display("FAIL basic_left got=%h want=aaaa", l); end
    total++; if (r !== 16'hBBBB) begin bad++; $display("FAIL basic_right got=%h want=bbbb", r); end
    total++; if ({rq, rw} !== 2'b10) begin bad++; $display("FAIL basic_refill got req/word=%b/%b want 1/0", rq, rw); end
    cyc();
    total++; if ({valid0, rreq0, bif0.buf_ceb} !== 3'b000) begin bad++; $display("FAIL basic_after_pulses got=%b want=000", {valid0, rreq0, bif0.buf_ceb}); end
    total++; if (bif0.buf_adb !== 2'd1) begin bad++; $display("FAIL basic_adb_hold got=%0d want=1", bif0.buf_adb); end
    total++; if ({left0, right0} !== 32'hAAAA_BBBB) begin bad++; $display("FAIL basic_pcm_hold got=%h want=aaaabbbb", {left0, right0}); end
  endtask

  task automatic test_ping_pong();
    logic c0, c1, v2, v3, rq, rw;
    logic [1:0] a0, a1;
    logic [15:0] l, r;
    write_word(1'b0, 32'h2222_1111);
    write_word(1'b1, 32'h4444_3333);
    run_read(c0, a0, c1, a1, v2, v3, l, r, rq, rw);
    total++; if ({a0, a1} !== 4'b10_11) begin bad++; $display("FAIL pp1_adb got=%0d,%0d want 2,3", a0, a1); end
    total++; if ({v3, l, r} !== {1'b1, 32'h3333_4444}) begin bad++; $display("FAIL pp1_pcm got=%b %h %h want 1 3333 4444", v3, l, r); end
    total++; if ({rq, rw} !== 2'b11) begin bad++; $display("FAIL pp1_refill got req/word=%b/%b want 1/1", rq, rw); end
    repeat (6) cyc();
    run_read(c0, a0, c1, a1, v2, v3, l, r, rq, rw);
    total++; if ({a0, a1} !== 4'b00_01) begin bad++; $display("FAIL pp2_adb got=%0d,%0d want 0,1", a0, a1); end
    total++; if ({v3, l, r} !== {1'b1, 32'h1111_2222}) begin bad++; $display("FAIL pp2_pcm got=%b %h %h want 1 1111 2222", v3, l, r); end
    total++; if ({rq, rw} !== 2'b10) begin bad++; $display("FAIL pp2_refill got req/word=%b/%b want 1/0", rq, rw); end
    total++; if (dut0.full_q !== 2'b00) begin bad++; $display("FAIL pp_full got=%b want=00", dut0.full_q); end
  endtask

  task automatic test_collision();
    int nvalid;
    logic ovr_t2;
    logic [31:0] pcm_t3;
    nvalid = 0; ovr_t2 = 1'b0; pcm_t3 = 32'h0;
    write_word(1'b1, 32'h6666_5555);
    cyc();
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b1;
    for (int i = 2; i < 8; i++) begin
      cyc();
      sample_tick = 1'b0;
      if (i == 2) ovr_t2 = ovr0;
      if (i == 3) pcm_t3 = {left0, right0};
      if (valid0) nvalid++;
    end
    total++; if (ovr_t2 !== 1'b1) begin bad++; $display("FAIL coll_overrun got=%b want=1", ovr_t2); end
    total++; if (nvalid != 1) begin bad++; $display("FAIL coll_valid_count got=%0d want=1", nvalid); end
    total++; if (pcm_t3 !== 32'h5555_6666) begin bad++; $display("FAIL coll_pcm got=%h want=55556666", pcm_t3); end
  endtask

  task automatic test_simul_set_clear();
    write_word(1'b0, 32'h8888_7777);
    cyc();
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    cyc();
    wr_strobe = 1'b1;
    wr_word = 1'b0;
    cyc();
    wr_strobe = 1'b0;
    total++; if ({rreq0, rword0} !== 2'b10) begin bad++; $display("FAIL simul_refill got req/word=%b/%b want 1/0", rreq0, rword0); end
    total++; if ({left0, right0} !== 32'h7777_8888) begin bad++; $display("FAIL simul_pcm got=%h want=77778888", {left0, right0}); end
    total++; if (dut0.full_q !== 2'b01) begin bad++; $display("FAIL simul_full got=%b want=01", dut0.full_q); end
  endtask

  task automatic test_underrun_hold();
    cyc();
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    total++; if ({und0, valid0} !== 2'b11) begin bad++; $display("FAIL und_pulses got=%b want=11", {und0, valid0}); end
    total++; if ({left0, right0} !== 32'h0) begin bad++; $display("FAIL und_zero_pcm got=%h want=0", {left0, right0}); end
    total++; if ({und1, valid1} !== 2'b11) begin bad++; $display("FAIL und_hold_pulses got=%b want=11", {und1, valid1}); end
    total++; if ({left1, right1} !== 32'h7777_8888) begin bad++; $display("FAIL und_hold_pcm got=%h want=77778888", {left1, right1}); end
  endtask

  task automatic test_enable();
    logic any;
    any = 1'b0;
    enable = 1'b0;
    write_word(1'b1, 32'hCCCC_DDDD);
    cyc();
    sample_tick = 1'b1;
    #1;
    any = bif0.buf_ceb;
    for (int i = 0; i < 4; i++) begin
      cyc();
      sample_tick = 1'b0;
      any = any | bif0.buf_ceb | valid0 | und0 | ovr0 | rreq0;
    end
    total++; if (any !== 1'b0) begin bad++; $display("FAIL en_off_pulses got=%b want=0", any); end
    enable = 1'b1;
    cyc();
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    enable = 1'b0;
    cyc();
    cyc();
    total++; if (valid0 !== 1'b1) begin bad++; $display("FAIL en_mid_valid got=%b want=1", valid0); end
    total++; if ({left0, right0, rword0} !== {32'hDDDD_CCCC, 1'b1}) begin bad++; $display("FAIL en_mid_data got=%h/%b want ddddcccc/1", {left0, right0}, rword0); end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid_read();
    int nvalid;
    nvalid = 0;
    cyc();
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    #1;
    total++; if (bif0.buf_ceb !== 1'b1) begin bad++; $display("FAIL rstmid_in_read got=%b want=1", bif0.buf_ceb); end
    rst_n = 1'b0;
    #1;
    total++; if ({bif0.buf_ceb, bif0.buf_adb, bif0.buf_oce} !== 4'b0_00_1) begin bad++; $display("FAIL rstmid_buf got=%b want=0001", {bif0.buf_ceb, bif0.buf_adb, bif0.buf_oce}); end
    total++; if ({left0, right0, left1, right1} !== 64'h0) begin bad++; $display("FAIL rstmid_pcm got=%h want=0", {left0, right0, left1, right1}); end
    total++; if ({valid0, rreq0, rword0, und0, ovr0} !== 5'b0) begin bad++; $display("FAIL rstmid_pulses got=%b want=00000", {valid0, rreq0, rword0, und0, ovr0}); end
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (valid0 | valid1) nvalid++;
    end
    total++; if (nvalid != 0) begin bad++; $display("FAIL rstmid_no_valid got=%0d want=0", nvalid); end
    cyc();
    sample_tick = 1'b1;
    #1;
    total++; if (bif0.buf_ceb !== 1'b0) begin bad++; $display("FAIL rstmid_post_ceb got=%b want=0", bif0.buf_ceb); end
    cyc();
    sample_tick = 1'b0;
    total++; if (und0 !== 1'b1) begin bad++; $display("FAIL rstmid_post_underrun got=%b want=1", und0); end
  endtask

  initial begin
    mem[0] = 32'h0;
    mem[1] = 32'h0;
    test_reset();
    test_first_underrun();
    test_basic();
    test_ping_pong();
    test_collision();
    test_simul_set_clear();
    test_underrun_hold();
    test_enable();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/audio_sample_reader.md
AUDIO_SAMPLE_READER -- requirements
Module: audio_sample_reader

Interface
REQ-001 Parameter HOLD_ON_UNDERRUN, default 0; on underrun, 0 = output zero samples and 1 = repeat the last samples.
REQ-002 clk  in  1  single clock; the block and the audio buffer read port (clkb) share it.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 enable  in  1  level; when low, new sample_tick pulses are ignored.
REQ-005 sample_tick  in  1  one-cycle strobe at the audio sample rate.
REQ-006 wr_strobe  in  1  one-cycle pulse; the writer has stored a 32-bit stereo word in the buffer.
REQ-007 wr_word  in  1  index (0/1) of the word written with wr_strobe; matches the writer's ada.
REQ-008 buf_ceb  out  1  buffer read-port clock enable.
REQ-009 buf_oce  out  1  buffer output clock enable; constant 1 (buffer is in bypass read mode).
REQ-010 buf_adb  out  2  buffer halfword read address {word, half}; half 0 = left (din[15:0]), half 1 = right (din[31:16]).
REQ-011 buf_dout  in  16  buffer read data; valid in the cycle after the read request.
REQ-012 pcm_left, pcm_right  out  16 each  stereo sample pair, held between updates.
REQ-013 pcm_valid  out  1  one-cycle pulse when pcm_left/pcm_right update.
REQ-014 refill_req  out  1  one-cycle pulse when a word has been consumed.
REQ-015 refill_word  out  1  index of the consumed word; valid with refill_req and held afterwards.
REQ-016 underrun  out  1  one-cycle pulse when a tick finds the current word empty.
REQ-017 tick_overrun  out  1  one-cycle pulse when a tick arrives while a read is in progress.

Function
REQ-018 Keep a 2-bit full-flag vector (one flag per word) and a read pointer rd_word; rd_word is 0 after reset.
REQ-019 A wr_strobe sets full[wr_word].
REQ-020 If a set and a clear of the same flag occur in the same cycle, the set wins.
REQ-021 FSM states:
  - IDLE, RD_L, RD_R.
  - IDLE -> RD_L when sample_tick & enable & full[rd_word].
  - RD_L -> RD_R unconditionally.
  - RD_R -> IDLE unconditionally.
REQ-022 In the IDLE->RD_L transition cycle (T): buf_ceb=1, buf_adb={rd_word,0}.
REQ-023 In RD_L (T+1): buf_ceb=1, buf_adb={rd_word,1}; left is captured from buf_dout at the end of T+1.
REQ-024 In RD_R (T+2): buf_dout is captured as right; full[rd_word] is cleared; rd_word toggles.
REQ-025 pcm_left, pcm_right and pcm_valid update in cycle T+3 (latency of 3 cycles from sample_tick).
REQ-026 refill_req pulses in cycle T+3, with refill_word = the index of the word just consumed.
REQ-027 buf_ceb is 0 and buf_adb holds its last value in all other cycles.
REQ-028 A sample_tick & enable in IDLE with full[rd_word]=0 causes all of the following, with no buffer read and rd_word unchanged:
  - underrun pulses in T+1;
  - pcm_valid pulses in T+1;
  - pcm_left/pcm_right = 0 if HOLD_ON_UNDERRUN=0, otherwise previous values.
REQ-029 A sample_tick in RD_L or RD_R is dropped and pulses tick_overrun in the next cycle; the in-progress read is unaffected.
REQ-030 Deasserting enable mid-read does not abort the read; the read completes normally.
REQ-031 Ticks with enable=0 produce no pulses of any kind.
REQ-032 rd_word wraps 1 -> 0.
REQ-033 The full flags never count beyond 1; a write to an already-full word simply overwrites it (no error flag).

Reset
REQ-034 While rst_n=0, asynchronously:
  - state=IDLE, rd_word=0, full=2'b00;
  - buf_ceb=0, buf_adb=0, buf_oce=1;
  - pcm_left=pcm_right=0;
  - pcm_valid, refill_req, refill_word, underrun, tick_overrun all 0.
REQ-035 Reset asserted mid-read abandons the read with no pulses, and does not update pcm_left/pcm_right.
REQ-036 The first tick after reset with no prior wr_strobe is an underrun.

Verification
REQ-037 Basic read: wr_strobe word0 with buffer word0=0xBBBB_AAAA; tick at T ->
  - buf_adb=0 at T and 1 at T+1;
  - pcm_valid at T+3 with left=0xAAAA, right=0xBBBB;
  - refill_req at T+3 with refill_word=0.
REQ-038 Ping-pong: fill words 0 and 1, issue 2 ticks 10 cycles apart -> second read uses buf_adb 2 then 3; refill_word=1; full ends at 00.
REQ-039 Underrun: tick with full=00 ->
  - underrun and pcm_valid at T+1;
  - pcm outputs = 0 (HOLD_ON_UNDERRUN=0), or previous values unchanged (HOLD_ON_UNDERRUN=1);
  - buf_ceb never asserted.
REQ-040 Collision: tick in RD_L -> tick_overrun one cycle later; still exactly one pcm_valid.
REQ-041 Simultaneous set/clear: wr_strobe word0 in the same cycle as RD_R of word0 -> full[0]=1 afterwards; refill_req still pulses.
REQ-042 Reset mid-read: rst_n low in RD_L -> all outputs at reset values immediately; no pcm_valid follows.
